adc_cnt_axil_slave: RTL
=======================

ADC_CNT_AXIL_SLAVE -- requirements
Module: adc_cnt_axil_slave

Interface
REQ-001 SHALL provide parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL provide parameter C_S_AXI_ADDR_WIDTH, default 4, AXI4-Lite byte-address width.
REQ-003 SHALL provide parameter ADC_WIDTH, default 12, ADC sample width.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, named as follows.
- s00_axi_aclk  input  1  single clock.
- s00_axi_aresetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have these AXI4-Lite write ports:
- s00_axi_awaddr  input  4  write address.
- s00_axi_awprot  input  3  ignored.
- s00_axi_awvalid/awready  in/out  1  AW handshake.
- s00_axi_wdata  input  32  write data.
- s00_axi_wstrb  input  4  byte enables.
- s00_axi_wvalid/wready  in/out  1  W handshake.
- s00_axi_bresp  output  2  write response, always 2'b00.
- s00_axi_bvalid/bready  out/in  1  B handshake.
REQ-006 SHALL have these AXI4-Lite read ports:
- s00_axi_araddr  input  4  read address.
- s00_axi_arprot  input  3  ignored.
- s00_axi_arvalid/arready  in/out  1  AR handshake.
- s00_axi_rdata  output  32  read data.
- s00_axi_rresp  output  2  read response, always 2'b00.
- s00_axi_rvalid/rready  out/in  1  R handshake.
REQ-007 SHALL have these ADC ports:
- adc_valid  input  1  sample strobe, one sample per high cycle.
- adc_data  input  12  unsigned sample.
- cnt_irq  output  1  high while COUNT is saturated.

Function
REQ-008 Register map SHALL be decoded on awaddr/araddr[3:2]; bits [1:0] are ignored:
- 0x0 CTRL: bit0 EN (R/W), bit1 CLR (write-1 pulse, reads 0), other bits read 0.
- 0x4 THRESH: [11:0] R/W, other bits read 0.
- 0x8 COUNT: read-only.
- 0xC STATUS: read-only; bit0 EN, bit1 SAT, [27:16] last accepted sample, other bits 0.
REQ-009 Write path: awready and wready SHALL pulse high together for exactly one cycle when awvalid && wvalid && !bvalid && !awready; no AW-only or W-only acceptance.
REQ-010 On that accept cycle, register bytes with wstrb[i]=1 SHALL update on the next edge; wstrb bytes=0 retain their value.
REQ-011 bvalid SHALL rise the cycle after the accept, hold until bready, then clear; a new write SHALL NOT be accepted while bvalid=1.
REQ-012 Writes to COUNT or STATUS SHALL be ignored and still respond OKAY.
REQ-013 Read path: arready SHALL pulse one cycle when arvalid && !rvalid && !arready.
REQ-014 rdata SHALL be captured on the AR accept edge; rvalid rises the next cycle; rdata and rvalid hold until rready.
REQ-015 Counting: when EN=1, adc_valid=1 and adc_data>=THRESH (unsigned compare), COUNT SHALL increment by 1 on the next edge.
REQ-016 COUNT SHALL saturate at 0xFFFFFFFF and set SAT=1; cnt_irq equals SAT.
REQ-017 Every adc_valid cycle SHALL update last-sample, regardless of EN.
REQ-018 A CLR write (wstrb[0]=1, wdata[1]=1) SHALL zero COUNT and SAT on the edge after the accept. CLR has priority over a same-cycle increment.
REQ-019 A read of COUNT in the same cycle as an increment SHALL return the pre-increment value.
REQ-020 EN and CLR written in the same beat SHALL both take effect; counting resumes the cycle after the clear.

Reset
REQ-021 While s00_axi_aresetn=0, the following SHALL all be 0 asynchronously, and held at 0 until the first edge after deassertion:
- awready, wready, bvalid, arready, rvalid, rdata, bresp, rresp.
- CTRL, THRESH, COUNT, SAT, last-sample, cnt_irq.
REQ-022 Reset mid-transaction SHALL abort it with no response; the master restarts after reset.

Structure
REQ-023 Package adc_cnt_pkg SHALL hold:
- register offsets (0x0, 0x4, 0x8, 0xC);
- CTRL/STATUS bit positions;
- ADC_WIDTH and COUNT_MAX constants.
REQ-024 Sub-module adc_cnt_core SHALL contain the compare/saturating counter/last-sample logic; the top holds the AXI4-Lite FSM and register file. Implementation target: 120-400 lines of RTL.

Verification
REQ-025 Write 0x0=0x00000001, 0x4=0x00000800, then read both -> rdata 0x00000001 and 0x00000800, resp OKAY.
REQ-026 EN=1, THRESH=0x800; drive samples 0x7FF, 0x800, 0xFFF, plus one cycle adc_valid=0 with data 0xFFF -> COUNT reads 2, STATUS[27:16]=0xFFF.
REQ-027 Write 0x8=0x12345678 and 0xC=0xFFFFFFFF -> both bresp OKAY; COUNT and STATUS unchanged.
REQ-028 Write 0x4=0xFFFFFFFF with wstrb=4'b0001 after THRESH=0x800 -> THRESH reads 0x000008FF.
REQ-029 Force COUNT=0xFFFFFFFE via core hierarchy, apply 3 qualifying samples -> COUNT 0xFFFFFFFF, cnt_irq=1. Write CTRL=0x3 -> COUNT 0, cnt_irq 0 next cycle.
REQ-030 Hold bready=0 and rready=0 for 10 cycles, and assert aresetn=0 during an outstanding bvalid -> bvalid/rvalid stable until ready; after reset all outputs 0.

Source files
------------

// File: rtl/adc_cnt_pkg.sv
// adc_cnt_pkg
// Shared constants and helpers for the ADC threshold counter slave:
// register byte offsets, CTRL/STATUS bit positions, default ADC sample
// width, the counter saturation value, the bus FSM state types and a
// byte-strobe merge helper.
package adc_cnt_pkg;

    localparam int          ADC_WIDTH = 12;
    localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

    // Register byte offsets; only bits [3:2] take part in decode.
    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_THRESH = 4'h4;
    localparam logic [3:0] OFF_COUNT  = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hC;

    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_CLR_BIT      = 1;
    localparam int STATUS_EN_BIT     = 0;
    localparam int STATUS_SAT_BIT    = 1;
    localparam int STATUS_SAMPLE_LSB = 16;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ACCEPT,
        WR_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ACCEPT,
        RD_DATA
    } rd_state_t;

    // Replace the bytes of old_word selected by strb with those of new_word.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/adc_cnt_axil_slave_if.sv
// adc_cnt_axil_slave_if
// AXI4-Lite bus bundle between a master (testbench / interconnect) and the
// ADC counter slave.
//   aw*/w*/b* : write address, write data and write response channels
//   ar*/r*    : read address and read data channels
// Modports: master drives valids/payloads and the response readies,
//           slave drives the address/data readies and the responses.
interface adc_cnt_axil_slave_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);

    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/adc_cnt_core.sv
// adc_cnt_core
// Threshold compare, saturating event counter and last-sample capture.
//   clk, rst_n   : clock, asynchronous active-low reset
//   en           : counting enable
//   clr          : one-cycle clear of count and sat (wins over an increment)
//   thresh       : unsigned threshold; samples >= thresh are counted
//   adc_valid    : sample strobe, adc_data valid while high
//   adc_data     : unsigned sample
//   count        : number of qualifying samples, saturating
//   sat          : set once count has reached its maximum
//   last_sample  : most recent strobed sample, captured regardless of en
module adc_cnt_core #(
    parameter int ADC_WIDTH = adc_cnt_pkg::ADC_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic [ADC_WIDTH-1:0] thresh,
    input  logic                 adc_valid,
    input  logic [ADC_WIDTH-1:0] adc_data,
    output logic [31:0]          count,
    output logic                 sat,
    output logic [ADC_WIDTH-1:0] last_sample
);
    import adc_cnt_pkg::*;

    logic hit;

    assign hit = en && adc_valid && (adc_data >= thresh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (hit) begin
            // Hold at the maximum instead of wrapping; sat marks arrival there.
            if (count != COUNT_MAX) count <= count + 32'd1;
            if (count >= COUNT_MAX - 32'd1) sat <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_sample <= '0;
        end else if (adc_valid) begin
            last_sample <= adc_data;
        end
    end

endmodule

// File: rtl/adc_cnt_axil_slave.sv
// adc_cnt_axil_slave
// AXI4-Lite register slave around adc_cnt_core.
//   s00_axi_aclk    : clock
//   s00_axi_aresetn : asynchronous active-low reset
//   s00_axi         : AXI4-Lite slave bus (responses always OKAY)
//   adc_valid       : ADC sample strobe
//   adc_data        : unsigned ADC sample
//   cnt_irq         : high while the counter is saturated
// Registers (decode on address bits [3:2]):
//   0x0 CTRL   bit0 EN (R/W), bit1 CLR (write-1 pulse, reads 0)
//   0x4 THRESH [ADC_WIDTH-1:0] R/W
//   0x8 COUNT  read-only
//   0xC STATUS bit0 EN, bit1 SAT, [16 +: ADC_WIDTH] last sample
module adc_cnt_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int ADC_WIDTH          = adc_cnt_pkg::ADC_WIDTH
) (
    input  logic                 s00_axi_aclk,
    input  logic                 s00_axi_aresetn,
    adc_cnt_axil_slave_if.slave  s00_axi,
    input  logic                 adc_valid,
    input  logic [ADC_WIDTH-1:0] adc_data,
    output logic                 cnt_irq
);
    import adc_cnt_pkg::*;

    wr_state_t                     wr_state;
    rd_state_t                     rd_state;
    logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr;
    logic [C_S_AXI_ADDR_WIDTH-1:0] rd_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;
    logic [31:0]                   thresh_word;
    logic                          wr_en;
    logic                          clr;
    logic                          en;
    logic [ADC_WIDTH-1:0]          thresh;
    logic [31:0]                   count;
    logic                          sat;
    logic [ADC_WIDTH-1:0]          last_sample;
    logic                          unused_ok;

    assign wr_addr = s00_axi.awaddr;
    assign rd_addr = s00_axi.araddr;

    // Registers update on the edge that completes the joint AW/W handshake.
    assign wr_en = s00_axi.awready && s00_axi.awvalid &&
                   s00_axi.wready  && s00_axi.wvalid;

    assign clr = wr_en && (wr_addr[3:2] == OFF_CTRL[3:2]) &&
                 s00_axi.wstrb[0] && s00_axi.wdata[CTRL_CLR_BIT];

    assign thresh_word = apply_wstrb({{(32-ADC_WIDTH){1'b0}}, thresh},
                                     s00_axi.wdata, s00_axi.wstrb);

    assign s00_axi.bresp = 2'b00;
    assign s00_axi.rresp = 2'b00;
    assign cnt_irq       = sat;

    assign unused_ok = ^{s00_axi.awprot, s00_axi.arprot, wr_addr[1:0],
                         rd_addr[1:0], thresh_word[31:ADC_WIDTH]};

    // Write channel: AW and W are only ever accepted together.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            wr_state        <= WR_IDLE;
            s00_axi.awready <= 1'b0;
            s00_axi.wready  <= 1'b0;
            s00_axi.bvalid  <= 1'b0;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (s00_axi.awvalid && s00_axi.wvalid) begin
                        s00_axi.awready <= 1'b1;
                        s00_axi.wready  <= 1'b1;
                        wr_state        <= WR_ACCEPT;
                    end
                end
                WR_ACCEPT: begin
                    s00_axi.awready <= 1'b0;
                    s00_axi.wready  <= 1'b0;
                    s00_axi.bvalid  <= 1'b1;
                    wr_state        <= WR_RESP;
                end
                WR_RESP: begin
                    if (s00_axi.bready) begin
                        s00_axi.bvalid <= 1'b0;
                        wr_state       <= WR_IDLE;
                    end
                end
                default: begin
                    s00_axi.awready <= 1'b0;
                    s00_axi.wready  <= 1'b0;
                    s00_axi.bvalid  <= 1'b0;
                    wr_state        <= WR_IDLE;
                end
            endcase
        end
    end

    // Read channel: rdata is sampled on the accept edge, so a COUNT read
    // racing an increment returns the value before that increment.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            rd_state        <= RD_IDLE;
            s00_axi.arready <= 1'b0;
            s00_axi.rvalid  <= 1'b0;
            s00_axi.rdata   <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (s00_axi.arvalid) begin
                        s00_axi.arready <= 1'b1;
                        rd_state        <= RD_ACCEPT;
                    end
                end
                RD_ACCEPT: begin
                    s00_axi.arready <= 1'b0;
                    s00_axi.rvalid  <= 1'b1;
                    s00_axi.rdata   <= rd_word;
                    rd_state        <= RD_DATA;
                end
                RD_DATA: begin
                    if (s00_axi.rready) begin
                        s00_axi.rvalid <= 1'b0;
                        rd_state       <= RD_IDLE;
                    end
                end
                default: begin
                    s00_axi.arready <= 1'b0;
                    s00_axi.rvalid  <= 1'b0;
                    rd_state        <= RD_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rd_word = '0;
        case (rd_addr[3:2])
            OFF_CTRL[3:2]:   rd_word[CTRL_EN_BIT] = en;
            OFF_THRESH[3:2]: rd_word[ADC_WIDTH-1:0] = thresh;
            OFF_COUNT[3:2]:  rd_word = count;
            OFF_STATUS[3:2]: begin
                rd_word[STATUS_EN_BIT]                    = en;
                rd_word[STATUS_SAT_BIT]                   = sat;
                rd_word[STATUS_SAMPLE_LSB +: ADC_WIDTH]   = last_sample;
            end
            default: rd_word = '0;
        endcase
    end

    // COUNT and STATUS are read-only: writes there complete but change nothing.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            en     <= 1'b0;
            thresh <= '0;
        end else if (wr_en) begin
            case (wr_addr[3:2])
                OFF_CTRL[3:2]: begin
                    if (s00_axi.wstrb[0]) en <= s00_axi.wdata[CTRL_EN_BIT];
                end
                OFF_THRESH[3:2]: thresh <= thresh_word[ADC_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    adc_cnt_core #(
        .ADC_WIDTH (ADC_WIDTH)
    ) u_core (
        .clk         (s00_axi_aclk),
        .rst_n       (s00_axi_aresetn),
        .en          (en),
        .clr         (clr),
        .thresh      (thresh),
        .adc_valid   (adc_valid),
        .adc_data    (adc_data),
        .count       (count),
        .sat         (sat),
        .last_sample (last_sample)
    );

endmodule
